rattlesnake_mem_arbiter: RTL and testbench
==========================================

# rattlesnake_mem_arbiter

Three-way arbiter and sequencer for the single shared Rattlesnake memory port. It sits between the OCD engine, the instruction-fetch stage and the load/store stage on one side and the memory array on the other. Each cycle it grants at most one access and drives the memory strobes. It tags the one-cycle-late read data back to the requester that issued the read. It also runs an OCD lock session that halts CPU traffic cleanly.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied code-fetch cycles before fetch outranks data.
- CNT_BITS, 3: width of the starvation counter; must satisfy 2^CNT_BITS > STARVE_LIMIT.

Ports (widths use `MEM_ADDR_BITS`, `XLEN`, `XLEN_BYTES`):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous clear, same effect as reset_n
- ocd_lock_req  in  1  OCD requests exclusive ownership
- ocd_lock_ack  out  1  OCD owns the port
- ocd_req / ocd_we  in  1 / 1  OCD access request; write when ocd_we=1
- ocd_addr / ocd_wdata  in  MEM_ADDR_BITS / XLEN
- ocd_gnt / ocd_rvalid  out  1 / 1
- code_req / code_addr  in  1 / MEM_ADDR_BITS
- code_gnt / code_rvalid  out  1 / 1
- data_req / data_be  in  1 / XLEN_BYTES  data_be≠0 means write with byte enables
- data_addr / data_wdata  in  MEM_ADDR_BITS / XLEN
- data_gnt / data_rvalid  out  1 / 1
- rdata  out  XLEN  read word, equal to mem_read_data
- mem_addr / mem_read_en / mem_write_en / mem_write_data  out  MEM_ADDR_BITS / 1 / XLEN_BYTES / XLEN
- mem_read_data  in  XLEN  synchronous RAM output, valid one cycle after mem_read_en

## Operation
- FSM states: S_CPU, S_DRAIN, S_OCD.
  - S_CPU, when ocd_lock_req=1, goes to S_DRAIN.
  - S_DRAIN always goes to S_OCD after one cycle.
  - S_OCD, when ocd_lock_req=0, goes to S_CPU.
  - ocd_lock_ack=1 only in S_OCD.
- Grant logic is combinational and issues in the same cycle as the request.
  - S_CPU priority: OCD first. Then code, if starve_cnt ≥ STARVE_LIMIT. Then data. Then code.
  - S_DRAIN: no grants.
  - S_OCD: only OCD is granted.
- Memory drive follows the winner:
  - mem_read_en=1 for any granted read.
  - mem_write_en is all-ones for an OCD write and data_be for a data write.
  - With no grant, all memory strobes are 0 and mem_addr/mem_write_data hold the last granted values.
- Writes complete in the grant cycle; they produce no rvalid.
- Read return: a registered owner tag is captured at grant. Next cycle exactly one of ocd_/code_/data_rvalid is 1, and rdata carries the word.
- starve_cnt behaviour:
  - Increments (saturating at 2^CNT_BITS−1) on each cycle with code_req=1 and code_gnt=0.
  - Clears on code_gnt.
  - Holds when code_req=0.
- Requester contract: hold req, addr and data stable until gnt. An unhandled deassertion before gnt is legal and simply withdraws the request.

## Timing
- Reset values (reset_n=0 or sync_reset=1):
  - FSM=S_CPU, starve_cnt=0, all rvalid=0, ocd_lock_ack=0.
  - Address/data holding registers=0.
  - Grants and memory strobes are 0 while reset_n=0.
- Read latency: grant at cycle N, rvalid and rdata at N+1. Back-to-back reads by any mix of requesters sustain one access per cycle.
- Lock latency: ocd_lock_req rises at N, state is S_DRAIN at N+1, ocd_lock_ack=1 at N+2. A CPU read granted at N returns its rvalid at N+1, before ack.
- Drop of ocd_lock_req at N: S_CPU at N+1, CPU grants resume at N+1.
- Simultaneous OCD and CPU requests in S_CPU: OCD wins; the CPU requester stalls.
- Reset mid-read: the pending rvalid is discarded and is never asserted.

## Structure
- The shared package holds:
  - owner-tag localparams OWN_NONE, OWN_OCD, OWN_CODE, OWN_DATA;
  - FSM state encodings.
- Sub-module mem_arb_prio: purely combinational priority encoder that takes the requests, the starve flag and the state, and outputs the one-hot grant.
- Top level holds the FSM, starvation counter, owner-tag register and memory mux.

## Test plan
- code_req and data_req held high for 12 cycles in S_CPU, STARVE_LIMIT=4: data granted 4 cycles, code granted cycle 5, pattern repeats, and code is never denied more than 4 consecutive cycles.
- Read data_addr=0x10 with mem_read_data returning 0xDEADBEEF next cycle: data_rvalid=1, rdata=0xDEADBEEF, other rvalids=0.
- Data write with data_be=4'b0011: mem_write_en=4'b0011, mem_read_en=0, and no rvalid the following cycle.
- Code read granted at N with ocd_lock_req raised at N: code_rvalid at N+1, ocd_lock_ack at N+2, and code_req is denied throughout S_OCD.
- ocd_req, code_req and data_req all high in S_CPU: only ocd_gnt=1; with ocd_we=1, mem_write_en=4'b1111.
- reset_n pulsed low the cycle after a data read grant: data_rvalid stays 0, FSM returns to S_CPU, starve_cnt=0.

Source files
------------

// File: rtl/rattlesnake_mem_arbiter_pkg.sv
// Shared types and constants for the Rattlesnake memory-port arbiter.
package rattlesnake_mem_arbiter_pkg;

  localparam int MEM_ADDR_BITS = 16;
  localparam int XLEN          = 32;
  localparam int XLEN_BYTES    = XLEN / 8;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_OCD  = 2'd1;
  localparam logic [1:0] OWN_CODE = 2'd2;
  localparam logic [1:0] OWN_DATA = 2'd3;

  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_DRAIN = 2'd1,
    S_OCD   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic ocd;
    logic code;
    logic data;
  } arb_gnt_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational priority encoder: picks at most one requester per cycle.
module mem_arb_prio
  import rattlesnake_mem_arbiter_pkg::*;
(
  input  logic       enable,
  input  arb_state_e state,
  input  logic       ocd_req,
  input  logic       code_req,
  input  logic       data_req,
  input  logic       starve,
  output arb_gnt_t   gnt
);

  always_comb begin
    gnt = '0;
    if (enable) begin
      case (state)
        S_CPU: begin
          if (ocd_req)                 gnt.ocd  = 1'b1;
          else if (code_req && starve) gnt.code = 1'b1;
          else if (data_req)           gnt.data = 1'b1;
          else if (code_req)           gnt.code = 1'b1;
        end
        S_OCD:   gnt.ocd = ocd_req;
        default: gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/rattlesnake_mem_arbiter.sv
// Three-way arbiter for the shared memory port with OCD lock sessions and
// owner-tagged read return.
module rattlesnake_mem_arbiter
  import rattlesnake_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_BITS     = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sync_reset,
  input  logic                     ocd_lock_req,
  output logic                     ocd_lock_ack,
  input  logic                     ocd_req,
  input  logic                     ocd_we,
  input  logic [MEM_ADDR_BITS-1:0] ocd_addr,
  input  logic [XLEN-1:0]          ocd_wdata,
  output logic                     ocd_gnt,
  output logic                     ocd_rvalid,
  input  logic                     code_req,
  input  logic [MEM_ADDR_BITS-1:0] code_addr,
  output logic                     code_gnt,
  output logic                     code_rvalid,
  input  logic                     data_req,
  input  logic [XLEN_BYTES-1:0]    data_be,
  input  logic [MEM_ADDR_BITS-1:0] data_addr,
  input  logic [XLEN-1:0]          data_wdata,
  output logic                     data_gnt,
  output logic                     data_rvalid,
  output logic [XLEN-1:0]          rdata,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic                     mem_read_en,
  output logic [XLEN_BYTES-1:0]    mem_write_en,
  output logic [XLEN-1:0]          mem_write_data,
  input  logic [XLEN-1:0]          mem_read_data
);

  arb_state_e               state_q;
  logic [CNT_BITS-1:0]      starve_cnt;
  logic [1:0]               owner_q, owner_d;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic [XLEN-1:0]          wdata_q;
  arb_gnt_t                 gnt;
  logic                     starve;

  assign starve = 32'(starve_cnt) >= STARVE_LIMIT;

  mem_arb_prio u_prio (
    .enable   (reset_n),
    .state    (state_q),
    .ocd_req  (ocd_req),
    .code_req (code_req),
    .data_req (data_req),
    .starve   (starve),
    .gnt      (gnt)
  );

  assign ocd_gnt  = gnt.ocd;
  assign code_gnt = gnt.code;
  assign data_gnt = gnt.data;

  // Idle cycles replay the held address/data so the RAM pins stay quiet.
  always_comb begin
    mem_addr       = addr_q;
    mem_write_data = wdata_q;
    mem_read_en    = 1'b0;
    mem_write_en   = '0;
    owner_d        = OWN_NONE;
    if (gnt.ocd) begin
      mem_addr       = ocd_addr;
      mem_write_data = ocd_wdata;
      if (ocd_we) begin
        mem_write_en = '1;
      end else begin
        mem_read_en = 1'b1;
        owner_d     = OWN_OCD;
      end
    end else if (gnt.code) begin
      mem_addr    = code_addr;
      mem_read_en = 1'b1;
      owner_d     = OWN_CODE;
    end else if (gnt.data) begin
      mem_addr       = data_addr;
      mem_write_data = data_wdata;
      if (|data_be) begin
        mem_write_en = data_be;
      end else begin
        mem_read_en = 1'b1;
        owner_d     = OWN_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_CPU;
      ocd_lock_ack <= 1'b0;
    end else if (sync_reset) begin
      state_q      <= S_CPU;
      ocd_lock_ack <= 1'b0;
    end else begin
      case (state_q)
        S_CPU: if (ocd_lock_req) state_q <= S_DRAIN;
        S_DRAIN: begin
          state_q      <= S_OCD;
          ocd_lock_ack <= 1'b1;
        end
        S_OCD: if (!ocd_lock_req) begin
          state_q      <= S_CPU;
          ocd_lock_ack <= 1'b0;
        end
        default: begin
          state_q      <= S_CPU;
          ocd_lock_ack <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      owner_q    <= OWN_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (sync_reset) begin
      starve_cnt <= '0;
      owner_q    <= OWN_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      owner_q <= owner_d;
      addr_q  <= mem_addr;
      wdata_q <= mem_write_data;
      if (gnt.code) begin
        starve_cnt <= '0;
      end else if (code_req && (starve_cnt != '1)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign ocd_rvalid  = (owner_q == OWN_OCD);
  assign code_rvalid = (owner_q == OWN_CODE);
  assign data_rvalid = (owner_q == OWN_DATA);
  assign rdata       = mem_read_data;

endmodule

// File: tb/tb_rattlesnake_mem_arbiter.sv
// Self-checking bench: scoreboarded read returns plus per-scenario grant checks.
module tb_rattlesnake_mem_arbiter;
  import rattlesnake_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset_n, sync_reset, ocd_lock_req, ocd_lock_ack;
  logic                     ocd_req, ocd_we, ocd_gnt, ocd_rvalid;
  logic [MEM_ADDR_BITS-1:0] ocd_addr, code_addr, data_addr, mem_addr;
  logic [XLEN-1:0]          ocd_wdata, data_wdata, rdata, mem_write_data, mem_read_data;
  logic                     code_req, code_gnt, code_rvalid;
  logic                     data_req, data_gnt, data_rvalid, mem_read_en;
  logic [XLEN_BYTES-1:0]    data_be, mem_write_en;

  rattlesnake_mem_arbiter #(.STARVE_LIMIT(4), .CNT_BITS(3)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .ocd_lock_req(ocd_lock_req), .ocd_lock_ack(ocd_lock_ack),
    .ocd_req(ocd_req), .ocd_we(ocd_we), .ocd_addr(ocd_addr), .ocd_wdata(ocd_wdata),
    .ocd_gnt(ocd_gnt), .ocd_rvalid(ocd_rvalid),
    .code_req(code_req), .code_addr(code_addr), .code_gnt(code_gnt),
    .code_rvalid(code_rvalid),
    .data_req(data_req), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  typedef struct {
    int          due;
    logic [2:0]  own;   // {ocd, code, data}
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] ram [256];
  logic        wr_flag [256];
  logic [31:0] ram_old, ram_new;
  logic [2:0]  mon_rv;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {8'h5A, a, ~a, a};
  endfunction

  function automatic logic [31:0] ram_word(input logic [7:0] a);
    if (wr_flag[a] === 1'b1) return ram[a];
    return init_word(a);
  endfunction

  // Synchronous RAM model: data appears one cycle after mem_read_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read_en) mem_read_data <= ram_word(mem_addr[7:0]);
    if (|mem_write_en) begin
      ram_old = ram_word(mem_addr[7:0]);
      for (int b = 0; b < 4; b++)
        ram_new[8*b +: 8] = mem_write_en[b] ? mem_write_data[8*b +: 8] : ram_old[8*b +: 8];
      ram[mem_addr[7:0]]     <= ram_new;
      wr_flag[mem_addr[7:0]] <= 1'b1;
    end
  end

  // Read-return scoreboard.
  always @(negedge clk) begin
    mon_rv = {ocd_rvalid, code_rvalid, data_rvalid};
    if (sb.size() != 0 && sb[0].due == cyc) begin
      n_checks++;
      if (mon_rv !== sb[0].own || rdata !== sb[0].data)
        $display("FAIL rvalid_return cyc=%0d got rv=%b rdata=%h exp rv=%b rdata=%h",
                 cyc, mon_rv, rdata, sb[0].own, sb[0].data);
      else n_pass++;
      void'(sb.pop_front());
    end else if (mon_rv !== 3'b000) begin
      n_checks++;
      $display("FAIL unexpected_rvalid cyc=%0d got rv=%b exp rv=000", cyc, mon_rv);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; code_req = 1'b1; data_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ocd_gnt, code_gnt, data_gnt, mem_read_en, mem_write_en} !== 7'b0)
      $display("FAIL reset_strobes got=%b exp=0",
               {ocd_gnt, code_gnt, data_gnt, mem_read_en, mem_write_en});
    else n_pass++;
    n_checks++;
    if ({ocd_lock_ack, ocd_rvalid, code_rvalid, data_rvalid} !== 4'b0 || mem_addr !== 16'h0)
      $display("FAIL reset_state got ack/rv=%b addr=%h exp 0/0",
               {ocd_lock_ack, ocd_rvalid, code_rvalid, data_rvalid}, mem_addr);
    else n_pass++;
    code_req = 1'b0; data_req = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_starvation();
    int  denied = 0;
    logic exp_code;
    code_req = 1'b1; code_addr = 16'h0020;
    data_req = 1'b1; data_addr = 16'h0030; data_be = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_code = (i % 5 == 4);
      n_checks++;
      if ({code_gnt, data_gnt} !== {exp_code, ~exp_code})
        $display("FAIL starve_gnt i=%0d got code/data=%b%b exp=%b%b",
                 i, code_gnt, data_gnt, exp_code, ~exp_code);
      else n_pass++;
      denied = code_gnt ? 0 : denied + 1;
      n_checks++;
      if (denied > 4) $display("FAIL starve_bound i=%0d got=%0d exp<=4", i, denied);
      else n_pass++;
      sb.push_back('{cyc + 1, exp_code ? 3'b010 : 3'b001,
                     ram_word(exp_code ? 8'h20 : 8'h30)});
      step();
    end
    data_req = 1'b0;  // lone code read clears the starvation count
    @(negedge clk);
    n_checks++;
    if (code_gnt !== 1'b1) $display("FAIL code_alone got=%b exp=1", code_gnt);
    else n_pass++;
    sb.push_back('{cyc + 1, 3'b010, ram_word(8'h20)});
    step();
    code_req = 1'b0;
  endtask

  task automatic test_data_read();
    data_req = 1'b1; data_addr = 16'h0010; data_be = '0;
    @(negedge clk);
    n_checks++;
    if ({data_gnt, mem_read_en} !== 2'b11 || mem_addr !== 16'h0010 || mem_write_en !== 4'h0)
      $display("FAIL data_read_drive got gnt/re=%b addr=%h we=%b exp 11/0010/0000",
               {data_gnt, mem_read_en}, mem_addr, mem_write_en);
    else n_pass++;
    sb.push_back('{cyc + 1, 3'b001, 32'hDEADBEEF});
    step();
    data_req = 1'b0;
    step();
  endtask

  task automatic test_data_write();
    logic [31:0] old = ram_word(8'h40);
    data_req = 1'b1; data_addr = 16'h0040; data_be = 4'b0011; data_wdata = 32'h12345678;
    @(negedge clk);
    n_checks++;
    if ({data_gnt, mem_read_en} !== 2'b10 || mem_write_en !== 4'b0011 ||
        mem_addr !== 16'h0040 || mem_write_data !== 32'h12345678)
      $display("FAIL data_write_drive got gnt/re=%b we=%b addr=%h wd=%h exp 10/0011/0040/12345678",
               {data_gnt, mem_read_en}, mem_write_en, mem_addr, mem_write_data);
    else n_pass++;
    step();
    data_req = 1'b0; data_be = '0;
    @(negedge clk);
    n_checks++;
    if ({ocd_rvalid, code_rvalid, data_rvalid} !== 3'b000)
      $display("FAIL write_no_rvalid got=%b exp=000", {ocd_rvalid, code_rvalid, data_rvalid});
    else n_pass++;
    n_checks++;
    if (mem_addr !== 16'h0040 || mem_write_data !== 32'h12345678 ||
        mem_write_en !== 4'h0 || mem_read_en !== 1'b0)
      $display("FAIL idle_hold got addr=%h wd=%h we=%b re=%b exp 0040/12345678/0000/0",
               mem_addr, mem_write_data, mem_write_en, mem_read_en);
    else n_pass++;
    step();
    data_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (data_gnt !== 1'b1) $display("FAIL readback_gnt got=%b exp=1", data_gnt);
    else n_pass++;
    sb.push_back('{cyc + 1, 3'b001, {old[31:16], 16'h5678}});
    step();
    data_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    ocd_req = 1'b1; ocd_we = 1'b0; ocd_addr = 16'h0070;
    @(negedge clk);
    n_checks++;
    if (ocd_gnt !== 1'b1) $display("FAIL b2b_ocd got=%b exp=1", ocd_gnt); else n_pass++;
    sb.push_back('{cyc + 1, 3'b100, ram_word(8'h70)});
    step();
    ocd_req = 1'b0; data_req = 1'b1; data_addr = 16'h0010;
    @(negedge clk);
    n_checks++;
    if (data_gnt !== 1'b1) $display("FAIL b2b_data got=%b exp=1", data_gnt); else n_pass++;
    sb.push_back('{cyc + 1, 3'b001, ram_word(8'h10)});
    step();
    data_req = 1'b0; code_req = 1'b1; code_addr = 16'h0020;
    @(negedge clk);
    n_checks++;
    if (code_gnt !== 1'b1) $display("FAIL b2b_code got=%b exp=1", code_gnt); else n_pass++;
    sb.push_back('{cyc + 1, 3'b010, ram_word(8'h20)});
    step();
    code_req = 1'b0;
  endtask

  task automatic test_ocd_priority();
    ocd_req = 1'b1; ocd_we = 1'b1; ocd_addr = 16'h0070; ocd_wdata = 32'hCAFEF00D;
    code_req = 1'b1; code_addr = 16'h0020;
    data_req = 1'b1; data_addr = 16'h0030; data_be = '0;
    @(negedge clk);
    n_checks++;
    if ({ocd_gnt, code_gnt, data_gnt} !== 3'b100 || mem_write_en !== 4'b1111 ||
        mem_read_en !== 1'b0 || mem_addr !== 16'h0070 || mem_write_data !== 32'hCAFEF00D)
      $display("FAIL ocd_prio got gnt=%b we=%b re=%b addr=%h wd=%h exp 100/1111/0/0070/cafef00d",
               {ocd_gnt, code_gnt, data_gnt}, mem_write_en, mem_read_en, mem_addr,
               mem_write_data);
    else n_pass++;
    step();
    ocd_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ocd_gnt, code_gnt, data_gnt} !== 3'b001)
      $display("FAIL after_ocd got=%b exp=001", {ocd_gnt, code_gnt, data_gnt});
    else n_pass++;
    sb.push_back('{cyc + 1, 3'b001, ram_word(8'h30)});
    step();
    data_req = 1'b0;
    @(negedge clk);
    sb.push_back('{cyc + 1, 3'b010, ram_word(8'h20)});
    step();
    code_req = 1'b0; ocd_req = 1'b1; ocd_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ocd_gnt !== 1'b1) $display("FAIL ocd_readback got=%b exp=1", ocd_gnt); else n_pass++;
    sb.push_back('{cyc + 1, 3'b100, 32'hCAFEF00D});
    step();
    ocd_req = 1'b0;
  endtask

  task automatic test_lock();
    code_req = 1'b1; code_addr = 16'h0020; ocd_lock_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({code_gnt, ocd_lock_ack} !== 2'b10)
      $display("FAIL lock_n got gnt/ack=%b exp=10", {code_gnt, ocd_lock_ack});
    else n_pass++;
    sb.push_back('{cyc + 1, 3'b010, ram_word(8'h20)});
    step();
    @(negedge clk);
    n_checks++;
    if ({code_gnt, ocd_lock_ack} !== 2'b00)
      $display("FAIL lock_drain got gnt/ack=%b exp=00", {code_gnt, ocd_lock_ack});
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++;
    if ({code_gnt, ocd_lock_ack} !== 2'b01)
      $display("FAIL lock_ack got gnt/ack=%b exp=01", {code_gnt, ocd_lock_ack});
    else n_pass++;
    step();
    ocd_req = 1'b1; ocd_we = 1'b0; ocd_addr = 16'h0010;
    @(negedge clk);
    n_checks++;
    if ({ocd_gnt, code_gnt} !== 2'b10)
      $display("FAIL lock_ocd_only got ocd/code=%b exp=10", {ocd_gnt, code_gnt});
    else n_pass++;
    sb.push_back('{cyc + 1, 3'b100, ram_word(8'h10)});
    step();
    ocd_req = 1'b0; ocd_lock_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({code_gnt, ocd_lock_ack} !== 2'b01)
      $display("FAIL unlock_n got gnt/ack=%b exp=01", {code_gnt, ocd_lock_ack});
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++;
    if ({code_gnt, ocd_lock_ack} !== 2'b10)
      $display("FAIL unlock_resume got gnt/ack=%b exp=10", {code_gnt, ocd_lock_ack});
    else n_pass++;
    sb.push_back('{cyc + 1, 3'b010, ram_word(8'h20)});
    step();
    code_req = 1'b0;
  endtask

  task automatic test_sync_reset();
    ocd_lock_req = 1'b1;
    step();
    step();
    @(negedge clk);
    n_checks++;
    if (ocd_lock_ack !== 1'b1) $display("FAIL sync_pre_ack got=%b exp=1", ocd_lock_ack);
    else n_pass++;
    step();
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0; ocd_lock_req = 1'b0; code_req = 1'b1; code_addr = 16'h0020;
    @(negedge clk);
    n_checks++;
    if ({code_gnt, ocd_lock_ack} !== 2'b10)
      $display("FAIL sync_reset_cpu got gnt/ack=%b exp=10", {code_gnt, ocd_lock_ack});
    else n_pass++;
    sb.push_back('{cyc + 1, 3'b010, ram_word(8'h20)});
    step();
    code_req = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    code_req = 1'b1; code_addr = 16'h0020;
    data_req = 1'b1; data_addr = 16'h0030; data_be = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (data_gnt !== 1'b1) $display("FAIL pre_reset_gnt i=%0d got=%b exp=1", i, data_gnt);
      else n_pass++;
      if (i < 3) sb.push_back('{cyc + 1, 3'b001, ram_word(8'h30)});
      step();
    end
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({data_rvalid, data_gnt, code_gnt} !== 3'b000)
      $display("FAIL reset_discard got rv/gnts=%b exp=000", {data_rvalid, data_gnt, code_gnt});
    else n_pass++;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({code_gnt, data_gnt, ocd_lock_ack} !== 3'b010)
      $display("FAIL post_reset got code/data/ack=%b exp=010",
               {code_gnt, data_gnt, ocd_lock_ack});
    else n_pass++;
    sb.push_back('{cyc + 1, 3'b001, ram_word(8'h30)});
    step();
    code_req = 1'b0; data_req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sync_reset = 1'b0; ocd_lock_req = 1'b0;
    ocd_req = 1'b0; ocd_we = 1'b0; ocd_addr = '0; ocd_wdata = '0;
    code_req = 1'b0; code_addr = '0;
    data_req = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
    #1;
    test_reset();
    test_starvation();
    test_data_read();
    test_data_write();
    test_back_to_back();
    test_ocd_priority();
    test_lock();
    test_sync_reset();
    test_reset_mid_read();
    repeat (3) step();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
